pdts_pll_rst_seq: RTL and testbench

//  Reset/lock sequencer upstream of the timing-system PLL (250 MHz ref -> 50 MHz out).
//  - Drives the PLL reset with a guaranteed minimum pulse.
//  - Watches the PLL locked flag and qualifies it as stable.
//  - Releases the downstream domain reset only after lock is stable.
//  - Automatically re-sequences on lock loss or lock timeout, with status counters.

---
 rtl/pdts_pll_pkg.sv | 19 +
 rtl/pdts_sync_bit.sv | 28 ++
 rtl/pdts_pll_rst_seq.sv | 133 +++++++++++++
 tb/tb_pdts_pll_rst_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdts_pll_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
// State encoding is exported on seq_state, so the values are fixed.
package pdts_pll_pkg;

   localparam int unsigned STAT_W = 8;

   typedef enum logic [1:0] {
      S_RESET_PLL = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_STABLE    = 2'd2,
      S_RUN       = 2'd3
   } seq_state_e;

   // Saturating increment for the status counters
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/pdts_sync_bit.sv
// Multi-stage single-bit synchroniser with asynchronous reset to 0.
module pdts_sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pdts_pll_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock stability and
// releases the downstream domain reset, re-sequencing on lock loss or timeout.
module pdts_pll_rst_seq
   import pdts_pll_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYC    = 256,
   parameter int unsigned LOCK_TIMEOUT_CYC = 1000000,
   parameter int unsigned LOCK_STABLE_CYC  = 4096,
   parameter int unsigned SYNC_STAGES      = 2,
   parameter int unsigned CNT_W            = 20
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              soft_rst,
   input  logic              pll_locked,
   output logic              pll_rst,
   output logic              pll_ready,
   output logic              domain_rst,
   output logic              lock_lost,
   output logic [STAT_W-1:0] relock_cnt,
   output logic [STAT_W-1:0] timeout_cnt,
   output logic [1:0]        seq_state
);

   localparam logic [CNT_W-1:0] RST_END     = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(LOCK_STABLE_CYC - 1);

   logic locked_s;

   pdts_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   seq_state_e        state_q,   state_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [STAT_W-1:0] relock_q,  relock_d;
   logic [STAT_W-1:0] timeout_q, timeout_d;
   logic              pll_rst_q, pll_rst_d;
   logic              ready_q,   ready_d;
   logic              dom_rst_q, dom_rst_d;
   logic              lost_q,    lost_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      relock_d  = relock_q;
      timeout_d = timeout_q;
      lost_d    = 1'b0;
      if (soft_rst) begin
         state_d = S_RESET_PLL;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_RESET_PLL: begin
               if (cnt_q == RST_END) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end
            end
            S_WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = S_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_END) begin
                  state_d   = S_RESET_PLL;
                  cnt_d     = '0;
                  timeout_d = sat_inc(timeout_q);
               end
            end
            S_STABLE: begin
               if (!locked_s) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_END) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
               end
            end
            S_RUN: begin
               if (!locked_s) begin
                  state_d  = S_RESET_PLL;
                  cnt_d    = '0;
                  relock_d = sat_inc(relock_q);
                  lost_d   = 1'b1;
               end
            end
            default: begin
               state_d = S_RESET_PLL;
               cnt_d   = '0;
            end
         endcase
      end
      // Outputs decode the next state so they change together with the state register
      pll_rst_d = (state_d == S_RESET_PLL);
      ready_d   = (state_d == S_RUN);
      dom_rst_d = (state_d != S_RUN);
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RESET_PLL;
         cnt_q     <= '0;
         relock_q  <= '0;
         timeout_q <= '0;
         pll_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         dom_rst_q <= 1'b1;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         relock_q  <= relock_d;
         timeout_q <= timeout_d;
         pll_rst_q <= pll_rst_d;
         ready_q   <= ready_d;
         dom_rst_q <= dom_rst_d;
         lost_q    <= lost_d;
      end
   end

   assign pll_rst     = pll_rst_q;
   assign pll_ready   = ready_q;
   assign domain_rst  = dom_rst_q;
   assign lock_lost   = lost_q;
   assign relock_cnt  = relock_q;
   assign timeout_cnt = timeout_q;
   assign seq_state   = state_q;

endmodule

// File: tb/tb_pdts_pll_rst_seq.sv
// Self-checking bench for pdts_pll_rst_seq: directed scenarios plus random
// lock/soft-reset stimulus, all outputs compared each cycle to a reference model.
module tb_pdts_pll_rst_seq;

   localparam int unsigned RST_PULSE  = 8;
   localparam int unsigned TIMEOUT    = 100;
   localparam int unsigned STABLE     = 16;
   localparam int unsigned SYNC       = 2;

   localparam int P_RST    = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;

   logic       refclk;
   logic       rst_n;
   logic       soft_rst;
   logic       pll_locked;
   logic       pll_rst;
   logic       pll_ready;
   logic       domain_rst;
   logic       lock_lost;
   logic [7:0] relock_cnt;
   logic [7:0] timeout_cnt;
   logic [1:0] seq_state;

   pdts_pll_rst_seq #(
      .RST_PULSE_CYC    (RST_PULSE),
      .LOCK_TIMEOUT_CYC (TIMEOUT),
      .LOCK_STABLE_CYC  (STABLE),
      .SYNC_STAGES      (SYNC),
      .CNT_W            (8)
   ) dut (
      .refclk      (refclk),
      .rst_n       (rst_n),
      .soft_rst    (soft_rst),
      .pll_locked  (pll_locked),
      .pll_rst     (pll_rst),
      .pll_ready   (pll_ready),
      .domain_rst  (domain_rst),
      .lock_lost   (lock_lost),
      .relock_cnt  (relock_cnt),
      .timeout_cnt (timeout_cnt),
      .seq_state   (seq_state)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   // Reference model: phase, cycles spent in phase, event counters, and a
   // delay line holding pll_locked as seen after the synchroniser.
   int m_ph;
   int m_el;
   int m_rel;
   int m_to;
   bit m_lost;
   bit lk_hist[$];

   function automatic int sat(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic model_reset();
      m_ph = P_RST; m_el = 0; m_rel = 0; m_to = 0; m_lost = 0;
      lk_hist.delete();
      for (int i = 0; i < int'(SYNC); i++) lk_hist.push_back(1'b0);
   endtask

   task automatic enter(input int ph);
      m_ph = ph;
      m_el = 0;
   endtask

   task automatic model_edge(input bit sr, input bit lk);
      bit ls;
      ls = lk_hist.pop_front();
      lk_hist.push_back(lk);
      m_lost = 0;
      if (sr) enter(P_RST);
      else begin
         case (m_ph)
            P_RST:    if (m_el + 1 == int'(RST_PULSE)) enter(P_WAIT); else m_el++;
            P_WAIT:   if (ls) enter(P_STABLE);
                      else if (m_el + 1 == int'(TIMEOUT)) begin enter(P_RST); m_to = sat(m_to); end
                      else m_el++;
            P_STABLE: if (!ls) enter(P_WAIT);
                      else if (m_el + 1 == int'(STABLE)) enter(P_RUN);
                      else m_el++;
            default:  if (!ls) begin enter(P_RST); m_rel = sat(m_rel); m_lost = 1; end
                      else m_el++;
         endcase
      end
   endtask

   task automatic compare_all(input string pfx);
      check({pfx, "_state"},   seq_state,   m_ph);
      check({pfx, "_pll_rst"}, pll_rst,     (m_ph == P_RST) ? 1 : 0);
      check({pfx, "_ready"},   pll_ready,   (m_ph == P_RUN) ? 1 : 0);
      check({pfx, "_dom_rst"}, domain_rst,  (m_ph == P_RUN) ? 0 : 1);
      check({pfx, "_lost"},    lock_lost,   m_lost);
      check({pfx, "_relock"},  relock_cnt,  m_rel);
      check({pfx, "_timeout"}, timeout_cnt, m_to);
   endtask

   // Called at a negedge; drives inputs, takes one active edge, checks, returns at next negedge.
   task automatic tick(input bit lk, input bit sr);
      pll_locked = lk;
      soft_rst   = sr;
      @(posedge refclk);
      model_edge(sr, lk);
      #1;
      cyc++;
      compare_all("cyc");
      @(negedge refclk);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0;
      #1;
      model_reset();
      check("async_pll_rst", pll_rst, 1);
      check("async_ready",   pll_ready, 0);
      check("async_dom_rst", domain_rst, 1);
      check("async_state",   seq_state, 0);
      check("async_relock",  relock_cnt, 0);
      check("async_timeout", timeout_cnt, 0);
      check("async_lost",    lock_lost, 0);
      @(negedge refclk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic run_until(input bit lk, input int ph, input int el, input int budget);
      int n;
      n = 0;
      while (!(m_ph == ph && (el < 0 || m_el == el)) && n < budget) begin
         tick(lk, 1'b0);
         n++;
      end
      if (!(m_ph == ph && (el < 0 || m_el == el))) check("reach_budget", m_ph, ph);
   endtask

   int saved;
   int ready_seen;
   int losses;
   int hold;
   bit lkv;
   bit srv;

   initial begin
      rst_n = 1'b0; soft_rst = 1'b0; pll_locked = 1'b0;
      @(negedge refclk);

      // 1: basic lock
      do_reset();
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, 1'b0);
         if (cyc == 7)  check("t1_rst7", pll_rst, 1);
         if (cyc == 8)  check("t1_wait8", seq_state, P_WAIT);
         if (cyc == 9)  check("t1_stable9", seq_state, P_STABLE);
         if (cyc == 24) check("t1_ready24", pll_ready, 0);
         if (cyc == 25) begin
            check("t1_ready25", pll_ready, 1);
            check("t1_dom25", domain_rst, 0);
         end
      end

      // 2: no lock
      do_reset();
      ready_seen = 0;
      for (int i = 0; i < 400; i++) begin
         tick(1'b0, 1'b0);
         if (pll_ready) ready_seen++;
         if (cyc == 108) check("t2_repulse108", pll_rst, 1);
         if (cyc == 323) check("t2_to323", timeout_cnt, 2);
         if (cyc == 324) check("t2_to324", timeout_cnt, 3);
      end
      check("t2_never_ready", ready_seen, 0);

      // 3: glitch during STABLE
      do_reset();
      run_until(1'b1, P_STABLE, 10, 100);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      run_until(1'b1, P_RUN, -1, 100);
      check("t3_relock", relock_cnt, 0);

      // 4: lock loss in RUN
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      check("t4_lost", lock_lost, 1);
      check("t4_relock", relock_cnt, 1);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b0);
         check("t4_dom_rst", domain_rst, 1);
      end

      // 5: soft reset in RUN and on the last WAIT_LOCK cycle
      run_until(1'b1, P_RUN, -1, 200);
      saved = m_rel;
      tick(1'b1, 1'b1);
      check("t5_run_state", seq_state, P_RST);
      check("t5_run_lost", lock_lost, 0);
      check("t5_run_relock", relock_cnt, saved);
      run_until(1'b0, P_WAIT, 99, 200);
      saved = m_to;
      tick(1'b0, 1'b1);
      check("t5_wait_state", seq_state, P_RST);
      check("t5_wait_timeout", timeout_cnt, saved);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);

      // 6: async reset mid-STABLE, then relock-counter saturation
      run_until(1'b1, P_STABLE, 5, 300);
      do_reset();
      losses = 0;
      for (int n = 0; n < 20000 && losses < 300; n++) begin
         tick((m_ph == P_RUN) ? 1'b0 : 1'b1, 1'b0);
         if (m_lost) losses++;
      end
      if (losses < 300) check("t6_budget", losses, 300);
      check("t6_sat", relock_cnt, 255);

      // Random lock behaviour and soft resets
      do_reset();
      hold = 0;
      for (int n = 0; n < 4000; n++) begin
         if (hold == 0) begin
            lkv  = ($urandom_range(0, 3) != 0);
            hold = $urandom_range(1, 150);
         end
         hold--;
         srv = ($urandom_range(0, 99) == 0);
         tick(lkv, srv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
